// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg: shared encodings, ASCII constants and FSM state type for the LCD result formatter.
package lcd_fmt_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam int ITEM_COUNT = 16;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/lcd_result_formatter_nibble_to_ascii.sv
// nibble_to_ascii: maps a 4-bit value to its uppercase hex ASCII character.
module nibble_to_ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);
  always_comb ascii_o = (nib_i < 4'd10) ? 8'h30 + {4'd0, nib_i} : 8'h37 + {4'd0, nib_i};
endmodule

// File: rtl/lcd_result_formatter.sv
// lcd_result_formatter: turns a latched FP result, opcode and flags into a 16-item
// LCD command/character stream over a valid/ready handshake.
module lcd_result_formatter
  import lcd_fmt_pkg::*;
#(
  parameter logic [7:0] LINE1_ADDR = 8'h80,
  parameter logic [7:0] LINE2_ADDR = 8'hC0
) (
  input  logic        Clk50Mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [1:0]  op,
  input  logic        flag_nan,
  input  logic        flag_ovf,
  input  logic        flag_unf,
  output logic        char_valid,
  output logic        char_rs,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        busy,
  output logic        done
);
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d, load;
  logic        rs_q;
  logic [7:0]  data_q;
  logic [31:0] res_q;
  logic [1:0]  op_q;
  logic [2:0]  flags_q;
  logic [3:0]  nib;
  logic [7:0]  hex_ch, op_ch, item_byte;
  logic [15:0] status;
  logic        item_rs;
  nibble_to_ascii u_hex (.nib_i(nib), .ascii_o(hex_ch));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: if (!valid_q) begin
        valid_d = 1'b1;
        load    = 1'b1;
      end else if (char_ready) begin
        if (idx_q == 4'(ITEM_COUNT - 1)) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else begin
          idx_d = idx_q + 4'd1;
          load  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // The next item is looked up from idx_d so the output byte is registered alongside its index.
  always_comb begin
    nib       = 4'(res_q >> {4'd10 - idx_d, 2'b00});
    op_ch     = op_q == OP_ADD ? CH_PLUS : op_q == OP_SUB ? CH_MINUS : op_q == OP_MUL ? CH_STAR : CH_SLASH;
    status    = flags_q[2] ? {CH_N, CH_A} : flags_q[1] ? {CH_O, CH_V} : flags_q[0] ? {CH_U, CH_F} : {CH_O, CH_K};
    item_rs   = !(idx_d == 4'd0 || idx_d == 4'd11);
    item_byte = idx_d == 4'd0  ? LINE1_ADDR :
                idx_d == 4'd1  ? CH_R :
                idx_d == 4'd2  ? CH_EQ :
                idx_d <= 4'd10 ? hex_ch :
                idx_d == 4'd11 ? LINE2_ADDR :
                idx_d == 4'd12 ? op_ch :
                idx_d == 4'd13 ? CH_SP :
                idx_d == 4'd14 ? status[15:8] : status[7:0];
  end
  always_ff @(posedge Clk50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      if (load) begin
        rs_q   <= item_rs;
        data_q <= item_byte;
      end
      if (state_q == IDLE && start) begin
        res_q   <= result;
        op_q    <= op;
        flags_q <= {flag_nan, flag_ovf, flag_unf};
      end
    end
  end
  assign char_valid = valid_q;
  assign char_rs    = rs_q;
  assign char_data  = data_q;
  assign busy       = state_q == SEND;
  assign done       = state_q == DONE;
endmodule
